// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline: load-use bubbles, EX redirects,
// multi-cycle data-memory waits, plus saturating stall/flush counters and a sticky timeout flag.
module pipe_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       ID_EX_rt,
    input  logic [4:0]       IF_ID_rs,
    input  logic [4:0]       IF_ID_rt,
    input  logic             IF_ID_uses_rt,
    input  logic             EX_redirect,
    input  logic             EX_MEM_mem_req,
    input  logic             dmem_ready,
    output logic             PC_en,
    output logic             IF_ID_en,
    output logic             ID_EX_en,
    output logic             EX_MEM_en,
    output logic             MEM_WB_en,
    output logic             IF_ID_flush,
    output logic             ID_EX_flush,
    output logic             EX_MEM_flush,
    output logic             MEM_WB_flush,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic {
        RUN,
        MEM_WAIT
    } state_t;

    localparam logic [15:0]      TIMEOUT_V = 16'(MEM_TIMEOUT);
    localparam logic [15:0]      WAIT_MAX  = 16'hFFFF;
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_t      state, state_nxt;
    logic [15:0] wait_cnt, wait_cnt_nxt;
    logic        mem_stall;
    logic        redirect_act;
    logic        load_use;

    assign mem_stall    = EX_MEM_mem_req && !dmem_ready;
    assign redirect_act = EX_redirect && !mem_stall;
    assign load_use     = ID_EX_MemRead && (ID_EX_rt != 5'd0) &&
                          ((ID_EX_rt == IF_ID_rs) || (IF_ID_uses_rt && (ID_EX_rt == IF_ID_rt)));

    // Pipeline controls; a frozen EX masks redirect and load-use until the memory releases.
    always_comb begin
        // NOTE: every output gets a default first so no path through the priority chain infers a latch.
        PC_en        = 1'b0;
        IF_ID_en     = 1'b0;
        ID_EX_en     = 1'b0;
        EX_MEM_en    = 1'b0;
        MEM_WB_en    = 1'b0;
        IF_ID_flush  = 1'b0;
        ID_EX_flush  = 1'b0;
        EX_MEM_flush = 1'b0;
        MEM_WB_flush = 1'b0;
        if (rst) begin
            if (mem_stall) begin
                MEM_WB_en    = 1'b1;
                MEM_WB_flush = 1'b1;
            end else if (EX_redirect) begin
                PC_en       = 1'b1;
                IF_ID_en    = 1'b1;
                ID_EX_en    = 1'b1;
                EX_MEM_en   = 1'b1;
                MEM_WB_en   = 1'b1;
                IF_ID_flush = 1'b1;
                ID_EX_flush = 1'b1;
            end else if (load_use) begin
                ID_EX_en    = 1'b1;
                EX_MEM_en   = 1'b1;
                MEM_WB_en   = 1'b1;
                ID_EX_flush = 1'b1;
            end else begin
                PC_en     = 1'b1;
                IF_ID_en  = 1'b1;
                ID_EX_en  = 1'b1;
                EX_MEM_en = 1'b1;
                MEM_WB_en = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            RUN: begin
                if (mem_stall) begin
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = 16'd1;
                end
            end
            MEM_WAIT: begin
                if (mem_stall) begin
                    if (wait_cnt != WAIT_MAX) wait_cnt_nxt = wait_cnt + 16'd1;
                end else begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = 16'd0;
                end
            end
            default: begin
                state_nxt    = RUN;
                wait_cnt_nxt = 16'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= RUN;
            wait_cnt    <= 16'd0;
            mem_timeout <= 1'b0;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading pre-edge values.
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if ((state == MEM_WAIT) && mem_stall && (wait_cnt == TIMEOUT_V)) mem_timeout <= 1'b1;
            if (!PC_en && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (redirect_act && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush sequencer for the 5-stage MIPS pipeline. It drives the enable and bubble-insert (flush) controls of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It covers three cases: load-use hazards, taken branches/jumps resolved in EX, and multi-cycle data-memory accesses in MEM. It also keeps saturating stall/flush performance counters and a sticky memory-timeout flag.

## Interface
- MEM_TIMEOUT, 64: MEM_WAIT cycles before `mem_timeout` sets (≥2).
- CNT_W, 16: width of performance counters.
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (rst=0 resets).
- ID_EX_MemRead  in  1  instruction in EX is a load.
- ID_EX_rt  in  5  destination register of the load in EX.
- IF_ID_rs  in  5  rs of the instruction in ID.
- IF_ID_rt  in  5  rt of the instruction in ID.
- IF_ID_uses_rt  in  1  ID instruction reads rt as a source.
- EX_redirect  in  1  branch taken or jump in EX this cycle.
- EX_MEM_mem_req  in  1  instruction in MEM accesses data memory.
- dmem_ready  in  1  data memory completes the access this cycle.
- PC_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en  out  1 each  register load enables.
- IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush  out  1 each  load a bubble (all-zero/NOP) instead of d.
- mem_timeout  out  1  sticky; a memory wait exceeded MEM_TIMEOUT.
- stall_cnt  out  CNT_W  cycles with PC_en=0, saturating.
- flush_cnt  out  CNT_W  redirect events, saturating.

## Operation
- States: RUN, MEM_WAIT. Internal wait_cnt is 16 bits wide.
- Control outputs are combinational from state and current inputs. The conditions below are listed in strict priority order.
- **1. Memory stall.** Active when EX_MEM_mem_req=1 and dmem_ready=0, in either state.
  - PC_en, IF_ID_en, ID_EX_en and EX_MEM_en are 0.
  - MEM_WB_en=1 and MEM_WB_flush=1, so a bubble goes to WB.
  - Every other flush is 0.
  - EX_redirect and load-use are ignored while EX is frozen; they are re-evaluated on release.
- **2. Redirect.** Active when EX_redirect=1 and there is no memory stall.
  - All enables are 1.
  - IF_ID_flush=1 and ID_EX_flush=1, killing the two younger instructions.
  - flush_cnt increments.
- **3. Load-use.** Active when ID_EX_MemRead=1, ID_EX_rt≠0, and either ID_EX_rt==IF_ID_rs or (IF_ID_uses_rt and ID_EX_rt==IF_ID_rt).
  - PC_en=0 and IF_ID_en=0.
  - ID_EX_flush=1, inserting one bubble.
  - EX_MEM and MEM_WB advance.
  - The hazard clears naturally the next cycle, giving exactly one bubble.
- **4. Default.** All enables are 1 and all flushes are 0.
- **Transitions.**
  - RUN → MEM_WAIT on a memory stall; wait_cnt←1.
  - MEM_WAIT stays in MEM_WAIT while dmem_ready=0; wait_cnt increments, saturating at 0xFFFF.
  - MEM_WAIT → RUN on the cycle dmem_ready=1. The release cycle uses normal priority 2–4; wait_cnt←0.
- **Timeout.** When wait_cnt==MEM_TIMEOUT and still not ready, mem_timeout←1. It stays set until reset; the stall continues.
- **stall_cnt.** Increments every cycle PC_en=0 (memory stall or load-use), saturating at all-ones.
- **Reset (rst=0, async).**
  - state=RUN, wait_cnt=0, mem_timeout=0, stall_cnt=0, flush_cnt=0.
  - While rst=0, all enables and all flushes are forced to 0.
  - A reset mid-MEM_WAIT aborts the wait immediately.

## Timing
- Stall/flush controls take effect on the same-cycle rising edge of the requesting condition; latency is zero.
- A load-use costs 1 cycle.
- A redirect costs 2 bubbles and no freeze.
- A memory access with N not-ready cycles freezes upstream for exactly N cycles. MEM_WB receives N bubbles.
- Counters and mem_timeout update at the edge ending the qualifying cycle.

## Test plan
- **Load-use.** ID_EX_MemRead=1, ID_EX_rt=5, IF_ID_rs=5 for one cycle → PC_en=0, IF_ID_en=0, ID_EX_flush=1 that cycle; stall_cnt 0→1. With IF_ID_uses_rt=0 and only rt=5, no stall. With ID_EX_rt=0, no stall.
- **Redirect.** EX_redirect=1 for one cycle with no other hazard → IF_ID_flush=ID_EX_flush=1, all enables 1; flush_cnt 0→1. The same cycle with a load-use also present gives redirect behaviour only.
- **Memory wait.** EX_MEM_mem_req=1, dmem_ready=0 for 3 cycles then 1 → upstream enables 0 and MEM_WB_flush=1 for exactly 3 cycles. State is MEM_WAIT for 3 cycles, then RUN; stall_cnt=3.
- **Stall vs redirect.** Memory stall for 2 cycles with EX_redirect held 1 → no IF_ID/ID_EX flush during the stall. On the release cycle IF_ID_flush=ID_EX_flush=1; flush_cnt +1 only.
- **Timeout.** MEM_TIMEOUT=4, dmem_ready held 0 for 6 cycles → mem_timeout rises after the 4th wait cycle's edge and stays 1 after ready returns. Assert rst=0 mid-wait → all outputs and counters 0 immediately; state RUN after release.
- **Saturation.** CNT_W=4, 20 load-use stalls → stall_cnt=15, holding there.
